// File: rtl/idu_dec_queue.sv
// Decode queue between IFU and EXU: pre-decodes each accepted instruction and
// buffers the decoded entry in a DEPTH-deep FIFO presented over valid/ready.
module idu_dec_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_fmt,
    output logic            out_wb,
    output logic            out_w,
    output logic            out_illegal,
    output logic [CW-1:0]   count
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [5:0]      fmt;
        logic            wb;
        logic            w;
        logic            illegal;
    } entry_t;

    function automatic entry_t f_decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        entry_t      e;
        logic [31:0] imm32;
        logic        fi, fu, fs, fj, fr, fb, known, w_op, ill, sys_priv;
        fi    = 1'b0;
        fu    = 1'b0;
        fs    = 1'b0;
        fj    = 1'b0;
        fr    = 1'b0;
        fb    = 1'b0;
        known = 1'b1;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:                         fu = 1'b1;
            OPC_JAL:                                    fj = 1'b1;
            OPC_JALR, OPC_LD, OPC_IMM, OPC_IMM32, OPC_SYS: fi = 1'b1;
            OPC_ST:                                     fs = 1'b1;
            OPC_OP, OPC_OP32:                           fr = 1'b1;
            OPC_BR:                                     fb = 1'b1;
            default:                                    known = 1'b0;
        endcase
        w_op     = (inst[6:0] == OPC_IMM32) || (inst[6:0] == OPC_OP32);
        ill      = (inst[1:0] != 2'b11) || !known || ((XLEN == 32) && w_op);
        sys_priv = (inst[6:0] == OPC_SYS) && (inst[14:12] == 3'b000);
        if (fi) begin
            imm32 = {{20{inst[31]}}, inst[31:20]};
        end else if (fs) begin
            imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end else if (fb) begin
            imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        end else if (fu) begin
            imm32 = {inst[31:12], 12'h000};
        end else if (fj) begin
            imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        end else begin
            imm32 = 32'h0000_0000;
        end
        e.pc   = pc;
        e.inst = inst;
        // Illegal entries travel to EXU with every decode attribute cleared.
        if (ill) begin
            e.imm     = '0;
            e.fmt     = 6'b000000;
            e.wb      = 1'b0;
            e.w       = 1'b0;
            e.illegal = 1'b1;
        end else begin
            e.imm     = XLEN'($signed(imm32));
            e.fmt     = {fb, fr, fj, fs, fu, fi};
            e.wb      = fr | fj | fu | (fi & ~sys_priv);
            e.w       = w_op;
            e.illegal = 1'b0;
        end
        return e;
    endfunction

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    entry_t        w_head;

    assign in_rdy  = (r_count != CW'(DEPTH));
    assign out_vld = (r_count != CW'(0));
    assign w_push  = in_vld & in_rdy;
    assign w_pop   = out_vld & out_rdy;
    assign w_head  = r_mem[r_rd_ptr];

    // Queue state: storage, wrapping pointers and occupancy; flush outranks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= f_decode(in_inst, in_pc);
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_pc      = w_head.pc;
    assign out_inst    = w_head.inst;
    assign out_rd      = w_head.inst[11:7];
    assign out_rs1     = w_head.inst[19:15];
    assign out_rs2     = w_head.inst[24:20];
    assign out_imm     = w_head.imm;
    assign out_fmt     = w_head.fmt;
    assign out_wb      = w_head.wb;
    assign out_w       = w_head.w;
    assign out_illegal = w_head.illegal;
    assign count       = r_count;

endmodule
